// File: rtl/sysarr_feeder.sv
// Operand staging and diagonal-skew feeder for a 4x4 systolic array.
// Holds A and B matrices, clears the accumulators, streams skewed rows/columns, then flags done.
module sysarr_feeder #(
  parameter int DW    = 32,
  parameter int DRAIN = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [1:0]    wr_row,
  input  logic [1:0]    wr_col,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  output logic [DW-1:0] l1,
  output logic [DW-1:0] l2,
  output logic [DW-1:0] l3,
  output logic [DW-1:0] l4,
  output logic [DW-1:0] u1,
  output logic [DW-1:0] u2,
  output logic [DW-1:0] u3,
  output logic [DW-1:0] u4,
  output logic          acc_clr,
  output logic          busy,
  output logic          done
);

  localparam int CW = $clog2(DRAIN + 1);
  localparam logic [2:0] LAST_STEP = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state_reg, state_next;
  logic [2:0]    step_reg, step_next;
  logic [CW-1:0] drain_reg, drain_next;

  logic [DW-1:0] a_mem [4][4];
  logic [DW-1:0] b_mem [4][4];
  logic [DW-1:0] l_vec [4];
  logic [DW-1:0] u_vec [4];
  logic          feeding;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      step_reg  <= '0;
      drain_reg <= '0;
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
      drain_reg <= drain_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    drain_next = drain_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_CLEAR;
      end
      S_CLEAR: begin
        state_next = S_FEED;
        step_next  = '0;
      end
      S_FEED: begin
        if (step_reg == LAST_STEP) begin
          state_next = S_DRAIN;
          drain_next = '0;
        end else begin
          step_next = step_reg + 3'd1;
        end
      end
      S_DRAIN: begin
        if (drain_reg == CW'(DRAIN - 1)) state_next = S_DONE;
        else drain_next = drain_reg + CW'(1);
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Writes only land while idle, so operands are frozen for the whole run.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          a_mem[r][c] <= '0;
          b_mem[r][c] <= '0;
        end
      end
    end else if (wr_en && state_reg == S_IDLE) begin
      if (wr_sel) b_mem[wr_row][wr_col] <= wr_data;
      else        a_mem[wr_row][wr_col] <= wr_data;
    end
  end

  assign feeding = (state_reg == S_FEED);

  // Lane gi is delayed by gi steps: row/column index k = t - gi.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : gen_feed
      logic [3:0] k_idx;
      logic       k_valid;
      assign k_idx   = {1'b0, step_reg} - 4'(gi);
      assign k_valid = feeding && ({1'b0, step_reg} >= 4'(gi)) && (k_idx <= 4'd3);
      assign l_vec[gi] = k_valid ? a_mem[gi][k_idx[1:0]] : '0;
      assign u_vec[gi] = k_valid ? b_mem[k_idx[1:0]][gi] : '0;
    end
  endgenerate

  assign l1 = l_vec[0];
  assign l2 = l_vec[1];
  assign l3 = l_vec[2];
  assign l4 = l_vec[3];
  assign u1 = u_vec[0];
  assign u2 = u_vec[1];
  assign u3 = u_vec[2];
  assign u4 = u_vec[3];

  assign acc_clr = (state_reg == S_CLEAR);
  assign busy    = (state_reg != S_IDLE);
  assign done    = (state_reg == S_DONE);

endmodule

// File: tb/tb_sysarr_feeder.sv
// Randomized and directed bench for sysarr_feeder against a cycle-position reference model,
// plus a small systolic-array model for an end-to-end product check.
module tb_sysarr_feeder;
  localparam int DW = 32;
  localparam int DRAIN = 4;
  localparam int DONE_POS = 9 + DRAIN;

  logic clk = 1'b0;
  logic rst, wr_en, wr_sel, start;
  logic [1:0] wr_row, wr_col;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] l1, l2, l3, l4, u1, u2, u3, u4;
  logic acc_clr, busy, done;

  logic [DW-1:0] lv [4];
  logic [DW-1:0] uv [4];
  assign lv[0] = l1; assign lv[1] = l2; assign lv[2] = l3; assign lv[3] = l4;
  assign uv[0] = u1; assign uv[1] = u2; assign uv[2] = u3; assign uv[3] = u4;

  always #5 clk = ~clk;

  sysarr_feeder #(.DW(DW), .DRAIN(DRAIN)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row),
    .wr_col(wr_col), .wr_data(wr_data), .start(start),
    .l1(l1), .l2(l2), .l3(l3), .l4(l4), .u1(u1), .u2(u2), .u3(u3), .u4(u4),
    .acc_clr(acc_clr), .busy(busy), .done(done)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: mpos = cycles since start acceptance (-1 when idle), plus latched matrices.
  int mpos = -1;
  logic [DW-1:0] ma [4][4];
  logic [DW-1:0] mb [4][4];

  always @(posedge clk) begin
    if (rst) begin
      mpos <= -1;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          ma[i][j] <= '0;
          mb[i][j] <= '0;
        end
    end else if (mpos < 0) begin
      if (wr_en) begin
        if (wr_sel) mb[wr_row][wr_col] <= wr_data;
        else        ma[wr_row][wr_col] <= wr_data;
      end
      if (start) mpos <= 1;
    end else if (mpos == DONE_POS) begin
      mpos <= -1;
    end else begin
      mpos <= mpos + 1;
    end
  end

  function automatic logic [DW-1:0] exp_l(input int i);
    int t;
    t = mpos - 2;
    if (mpos >= 2 && mpos <= 8 && t - i >= 0 && t - i <= 3) return ma[i][t - i];
    return '0;
  endfunction

  function automatic logic [DW-1:0] exp_u(input int j);
    int t;
    t = mpos - 2;
    if (mpos >= 2 && mpos <= 8 && t - j >= 0 && t - j <= 3) return mb[t - j][j];
    return '0;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("acc_clr", acc_clr, mpos == 1);
      chk("busy", busy, mpos >= 1);
      chk("done", done, mpos == DONE_POS);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("l%0d", i + 1), lv[i], exp_l(i));
        chk($sformatf("u%0d", i + 1), uv[i], exp_u(i));
      end
      if (done) $display("run complete at %0t", $time);
    end
  end

  // Systolic array model: A flows right, B flows down, one register per hop.
  logic [DW-1:0] acc [4][4];
  logic [DW-1:0] ar  [4][4];
  logic [DW-1:0] br  [4][4];

  function automatic logic [DW-1:0] ain(input int i, input int j);
    if (j == 0) return lv[i];
    return ar[i][j - 1];
  endfunction

  function automatic logic [DW-1:0] bin(input int i, input int j);
    if (i == 0) return uv[j];
    return br[i - 1][j];
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        if (acc_clr) begin
          acc[i][j] <= '0;
          ar[i][j]  <= '0;
          br[i][j]  <= '0;
        end else begin
          acc[i][j] <= acc[i][j] + ain(i, j) * bin(i, j);
          ar[i][j]  <= ain(i, j);
          br[i][j]  <= bin(i, j);
        end
      end
  end

  task automatic write_word(input bit sel, input int r, input int c, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_row = 2'(r); wr_col = 2'(c); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    int dn;
    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0; start = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_busy", busy, 0);
    chk("reset_l1", l1, 0);
    chk("reset_done", done, 0);
    rst = 1'b0;

    // Skew pattern load
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) write_word(1'b0, i, k, DW'(10 * i + k + 1));
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++) write_word(1'b1, k, j, DW'(100 + 10 * k + j));

    // Run 1: timing, skew values, blocked write/start at cycle 4
    start = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 14; k++) begin
      chk("t_acc_clr", acc_clr, k == 1);
      chk("t_busy", busy, k <= 13);
      chk("t_done", done, k == 13);
      if (k == 2) begin
        chk("s0_l1", l1, 1);    chk("s0_l2", l2, 0); chk("s0_l3", l3, 0); chk("s0_l4", l4, 0);
        chk("s0_u1", u1, 100);  chk("s0_u2", u2, 0); chk("s0_u3", u3, 0); chk("s0_u4", u4, 0);
      end
      if (k == 5) begin
        chk("s3_l1", l1, 4);    chk("s3_l2", l2, 13);  chk("s3_l3", l3, 22);  chk("s3_l4", l4, 31);
        chk("s3_u1", u1, 130);  chk("s3_u2", u2, 121); chk("s3_u3", u3, 112); chk("s3_u4", u4, 103);
      end
      if (k == 8) begin
        chk("s6_l1", l1, 0); chk("s6_l4", l4, 34); chk("s6_u1", u1, 0); chk("s6_u4", u4, 133);
      end
      start = (k == 4);
      wr_en = (k == 4); wr_sel = 1'b0; wr_row = 2'd0; wr_col = 2'd0; wr_data = 99;
      @(negedge clk);
    end
    wr_en = 1'b0;

    // Run 2: start held high across DONE restarts back-to-back
    start = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 15; k++) begin
      if (k == 2) chk("blocked_write_l1", l1, 1);
      if (k == 13) chk("r2_done", done, 1);
      if (k == 14) chk("r2_idle_busy", busy, 0);
      if (k == 15) begin
        chk("b2b_acc_clr", acc_clr, 1);
        start = 1'b0;
      end
      if (k < 15) @(negedge clk);
    end
    repeat (14) @(negedge clk);

    // Simultaneous write and start
    wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd1; wr_col = 2'd0; wr_data = 77; start = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    chk("simul_l2", l2, 77);
    chk("simul_l1", l1, 2);
    repeat (11) @(negedge clk);

    // Mid-run reset at FEED t=3
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_l1", l1, 4);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_l4", l4, 0);
    rst = 1'b0;
    dn = 0;
    repeat (16) begin
      if (done) dn++;
      @(negedge clk);
    end
    chk("mid_rst_no_done", dn, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("cleared_l1", l1, 0);
    chk("cleared_u1", u1, 0);
    repeat (12) @(negedge clk);

    // End-to-end: A = 2*I, B[k][j] = 4k+j+1
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) write_word(1'b0, i, k, (i == k) ? 2 : 0);
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++) write_word(1'b1, k, j, DW'(4 * k + j + 1));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("e2e_done", done, 1);
    chk("e2e_r11", acc[0][0], 2);
    chk("e2e_r44", acc[3][3], 32);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        chk($sformatf("e2e_r%0d%0d", i + 1, j + 1), acc[i][j], 64'(2 * (4 * i + j + 1)));
    @(negedge clk);

    // Random traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      wr_en = $urandom_range(0, 1) == 1;
      wr_sel = $urandom_range(0, 1) == 1;
      wr_row = 2'($urandom_range(0, 3));
      wr_col = 2'($urandom_range(0, 3));
      wr_data = $urandom;
      start = ($urandom_range(0, 7) == 0);
      @(negedge clk);
    end

    // Two-cycle reset under traffic, then a read-back run must be all zeros
    rst = 1'b1; start = 1'b1; wr_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rnd_rst_busy", busy, 0);
    chk("rnd_rst_l1", l1, 0);
    rst = 1'b0; wr_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("readback_l1", l1, 0);
    chk("readback_u4", u4, 0);
    repeat (12) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
